unit_nton: RTL
==============

UNIT_NTON -- requirements
Module: unit_nton

Interface
REQ-001 SHALL have parameter WIDTH, default 3, lane count of fin/fout/bin/bout (range 1..16).
REQ-002 SHALL have parameter THRESHOLD, default 255, flip threshold magnitude (range 1..1023).
REQ-003 SHALL have parameter PROB, default 256, stochastic update acceptance (update applied when rnd_in < PROB; 256 = always).
REQ-004 SHALL have parameter COOLDOWN, default 0, number of accepted backward updates after a flip during which no flip may occur.
REQ-005 SHALL have parameter INIT_W, default 0, reset value of the weight bit.
REQ-006 SHALL have port clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_in  input  1  reset; asynchronous, active-high.
REQ-008 SHALL have port rnd_in  input  8  random byte for stochastic gating.
REQ-009 SHALL have port fd_prop  input  1  forward strobe; captures fin.
REQ-010 SHALL have port bk_prop  input  1  backward strobe; consumes bin.
REQ-011 SHALL have port fin  input  WIDTH  forward operand.
REQ-012 SHALL have port bin  input  WIDTH  backward error vector; 1 = lane wrong.
REQ-013 SHALL have port load_en  input  1  weight load strobe.
REQ-014 SHALL have port load_val  input  1  weight value for load.
REQ-015 SHALL have port control_out  output  1  current weight w.
REQ-016 SHALL have port fout  output  WIDTH  registered forward result.
REQ-017 SHALL have port bout  output  WIDTH  registered backward result.
REQ-018 SHALL have port flip_out  output  1  one-cycle pulse, high the cycle after w flips by threshold.
REQ-019 SHALL have port bk_err  output  1  sticky flag: bk_prop seen with no pending forward.

Function
REQ-020 SHALL hold state IDLE/HELD: fd_prop moves to (or stays in) HELD; accepted bk_prop in HELD returns to IDLE.
REQ-021 On fd_prop: fout <= fin XOR {WIDTH{w}}, saved_w <= w; fout valid one cycle after strobe, held until next fd_prop.
REQ-022 On bk_prop in HELD: bout <= bin XOR {WIDTH{saved_w}}; bout held until next accepted bk_prop.
REQ-023 bk_prop in IDLE SHALL be ignored (bout, accumulator, state unchanged) and set bk_err.
REQ-024 fd_prop and bk_prop same cycle in HELD: backward uses old saved_w, then fd captures; state stays HELD.
REQ-025 fd_prop and bk_prop same cycle in IDLE: fd captures, bk ignored, bk_err set.
REQ-026 Accepted bk update delta = 2*popcount(bin) - WIDTH (signed); applied to acc only if rnd_in < PROB, else acc unchanged (bout still updates).
REQ-027 acc SHALL be signed, wide enough for THRESHOLD+WIDTH without overflow; acc_next = clamp(acc + delta, -THRESHOLD, +THRESHOLD).
REQ-028 If applied update gives acc_next == +THRESHOLD and cooldown count == 0: w <= ~w, acc <= 0, cooldown <= COOLDOWN, flip_out pulses next cycle.
REQ-029 If cooldown count > 0: each applied update decrements it, acc <= acc_next, no flip.
REQ-030 Flip SHALL not alter saved_w; the pending/next backward uses w as captured at its fd_prop.
REQ-031 load_en: w <= load_val, acc <= 0, cooldown <= 0, no flip_out; load_en wins over a same-cycle threshold flip; fd_prop in same cycle captures pre-load w.
REQ-032 flip_out SHALL be low in every cycle other than the one following a threshold flip.

Reset
REQ-033 rst_in high SHALL immediately force: fout=0, bout=0, w=INIT_W, saved_w=INIT_W, acc=0, cooldown=0, state=IDLE, flip_out=0, bk_err=0; strobes ignored while asserted, including mid-HELD.

Verification (WIDTH=3, THRESHOLD=4, PROB=256, COOLDOWN=1, INIT_W=0 unless stated)
REQ-034 Reset pulse, then fd fin=101 -> fout=101 next cycle; load 1, fd fin=101 -> fout=010, control_out=1.
REQ-035 fd; bk bin=111; fd; bk bin=111 -> bout=111, acc 3 then clamp 4 -> control_out=1, flip_out one-cycle pulse, acc=0.
REQ-036 After REQ-035 flip: two fd/bk pairs bin=111 -> first in cooldown (acc=3, no flip), second flips w back to 0 with flip_out.
REQ-037 bk_prop with no prior fd after reset -> bout=000, control_out unchanged, bk_err=1 and stays 1 until rst_in.
REQ-038 PROB=128: fd; bk bin=111 rnd_in=200 -> acc unchanged, bout=111; repeat with rnd_in=10 -> acc=3.
REQ-039 fd fin=111, assert rst_in asynchronously before clock edge -> fout=000 at once; following bk_prop -> bk_err=1.

Source files
------------

// File: rtl/unit_nton_if.sv
// Bus bundle for unit_nton: forward/backward strobes and operands in,
// registered results, weight and status flags out.
//
// Strobe semantics: fd_prop, bk_prop and load_en are single-cycle commands
// sampled on the rising clock edge. There is no back-pressure. The unit
// accepts every strobe in the cycle it is high. A bk_prop that arrives
// with no pending forward is dropped and raises the sticky bk_err flag.
// The results (fout, bout) are registered, hold their value until the
// next accepted strobe of the same kind, and are valid one cycle after
// that strobe.
interface unit_nton_if #(
    parameter int WIDTH = 3
);
    logic [7:0]       rnd_in;
    logic             fd_prop;
    logic             bk_prop;
    logic [WIDTH-1:0] fin;
    logic [WIDTH-1:0] bin;
    logic             load_en;
    logic             load_val;
    logic             control_out;
    logic [WIDTH-1:0] fout;
    logic [WIDTH-1:0] bout;
    logic             flip_out;
    logic             bk_err;
    logic             held_dbg;

    modport master (
        output rnd_in, fd_prop, bk_prop, fin, bin, load_en, load_val,
        input  control_out, fout, bout, flip_out, bk_err, held_dbg
    );

    modport slave (
        input  rnd_in, fd_prop, bk_prop, fin, bin, load_en, load_val,
        output control_out, fout, bout, flip_out, bk_err, held_dbg
    );
endinterface

// File: rtl/unit_nton.sv
// unit_nton: a single trainable sign bit w.
// The forward path XORs the operand lanes with w. The backward path XORs
// the error lanes with the w captured at the matching forward. Every
// accepted backward nudges a saturating accumulator, and w flips when
// that accumulator reaches +THRESHOLD.
module unit_nton #(
    parameter int   WIDTH     = 3,
    parameter int   THRESHOLD = 255,
    parameter int   PROB      = 256,
    parameter int   COOLDOWN  = 0,
    parameter logic INIT_W    = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    unit_nton_if.slave  bus
);
    // The accumulator is clamped to +/-THRESHOLD. The raw sum before
    // clamping can overshoot by up to WIDTH, so it is computed in int.
    localparam int ACC_W = $clog2(THRESHOLD + WIDTH + 1) + 1;
    // Width is at least 1 even when COOLDOWN is 0.
    localparam int CD_W  = $clog2(COOLDOWN + 2);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    bk_accept;
    logic                    bk_reject;

    logic                    w_q;
    logic                    saved_w_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CD_W-1:0]         cd_q;
    logic [WIDTH-1:0]        fout_q;
    logic [WIDTH-1:0]        bout_q;
    logic                    flip_q;
    logic                    err_q;

    int                      ones_i;
    int                      sum_i;
    int                      next_i;
    logic signed [ACC_W-1:0] acc_next;
    logic                    prob_ok;
    logic                    update_en;
    logic                    flip_now;

    // FSM state register: HELD means a forward is waiting for its backward.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and accept/reject decode for the backward strobe.
    always_comb begin
        state_d   = state_q;
        bk_accept = 1'b0;
        bk_reject = 1'b0;
        case (state_q)
            IDLE: begin
                bk_reject = bus.bk_prop;
                if (bus.fd_prop) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                bk_accept = bus.bk_prop;
                // A forward in the same cycle as a backward re-arms HELD.
                if (bus.fd_prop) begin
                    state_d = HELD;
                end else if (bus.bk_prop) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Compute the accumulator step: delta = 2*popcount(bin) - WIDTH, then clamp.
    always_comb begin
        ones_i = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_i = ones_i + int'(bus.bin[i]);
        end
        sum_i = int'(acc_q) + 2 * ones_i - WIDTH;
        if (sum_i > THRESHOLD) begin
            next_i = THRESHOLD;
        end else if (sum_i < -THRESHOLD) begin
            next_i = -THRESHOLD;
        end else begin
            next_i = sum_i;
        end
        acc_next = ACC_W'(next_i);
    end

    // Stochastic gate and flip decision. A load in the same cycle cancels the flip.
    always_comb begin
        prob_ok   = int'(bus.rnd_in) < PROB;
        update_en = bk_accept && prob_ok;
        flip_now  = update_en && (cd_q == '0) && (next_i == THRESHOLD)
                    && !bus.load_en;
    end

    // Weight, accumulator and cooldown. Load takes priority over any update.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            w_q   <= INIT_W;
            acc_q <= '0;
            cd_q  <= '0;
        end else if (bus.load_en) begin
            w_q   <= bus.load_val;
            acc_q <= '0;
            cd_q  <= '0;
        end else if (update_en) begin
            if (flip_now) begin
                w_q   <= ~w_q;
                acc_q <= '0;
                cd_q  <= CD_W'(COOLDOWN);
            end else begin
                acc_q <= acc_next;
                if (cd_q != '0) begin
                    cd_q <= cd_q - CD_W'(1);
                end
            end
        end
    end

    // One-cycle flip pulse, aligned with the first cycle of the new w.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            flip_q <= 1'b0;
        end else begin
            flip_q <= flip_now;
        end
    end

    // Forward capture uses w as it was before any same-cycle load or flip.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fout_q    <= '0;
            saved_w_q <= INIT_W;
        end else if (bus.fd_prop) begin
            fout_q    <= bus.fin ^ {WIDTH{w_q}};
            saved_w_q <= w_q;
        end
    end

    // Backward result uses the w captured at the matching forward.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bout_q <= '0;
        end else if (bk_accept) begin
            bout_q <= bus.bin ^ {WIDTH{saved_w_q}};
        end
    end

    // Sticky flag for a backward with no pending forward; only reset clears it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (bk_reject) begin
            err_q <= 1'b1;
        end
    end

    assign bus.control_out = w_q;
    assign bus.fout        = fout_q;
    assign bus.bout        = bout_q;
    assign bus.flip_out    = flip_q;
    assign bus.bk_err      = err_q;
    assign bus.held_dbg    = (state_q == HELD);

endmodule
